// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the serializer FSM encoding, idle line level and bit-period helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_e;

   localparam logic IDLE_LEVEL = 1'b1;

   // Integer-truncated number of clock cycles per serial bit.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
// restart_i forces the count back to zero so a new bit starts on the following cycle.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic bit_end_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;

   assign bit_end_o = (cnt_r == LAST_CNT);

   // Cycle counter: wraps on bit end, cleared on restart or reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_r <= '0;
      end else if (restart_i || bit_end_o) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by a show-ahead FIFO; pops one byte per frame and
// sends frames back-to-back while the FIFO holds data.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_re_o,
   output logic                  tx_o,
   output logic                  busy_o
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_WIDTH < 2) begin : g_bad_width
      $error("uart_tx_serializer: DATA_WIDTH must be at least 2");
   end

   uart_tx_state_e        state_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [IDX_W-1:0]      bit_idx_r;
   logic                  tx_r;
   logic                  busy_r;
   logic                  bit_end;
   logic                  pop;
   logic                  timer_restart;

   // A pop can only happen from IDLE or on the last STOP cycle, so frames chain with no gap.
   assign pop = rst_ni & ~fifo_empty_i &
                ((state_r == IDLE) | ((state_r == STOP) & bit_end));
   assign timer_restart = pop | (state_r == IDLE);

   assign fifo_re_o = pop;
   assign tx_o      = tx_r;
   assign busy_o    = busy_r;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (timer_restart),
      .bit_end_o (bit_end)
   );

   // Frame FSM; tx and busy are loaded with the level of the state being entered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r   <= IDLE;
         shift_r   <= '0;
         bit_idx_r <= '0;
         tx_r      <= IDLE_LEVEL;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop) begin
                  shift_r <= fifo_rdata_i;
                  state_r <= START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  tx_r    <= IDLE_LEVEL;
                  busy_r  <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state_r   <= DATA;
                  bit_idx_r <= '0;
                  tx_r      <= shift_r[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_r <= shift_r >> 1;
                  if (bit_idx_r == LAST_IDX) begin
                     state_r <= STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + IDX_W'(1);
                     tx_r      <= shift_r[1];
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift_r <= fifo_rdata_i;
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     tx_r    <= IDLE_LEVEL;
                     busy_r  <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= IDLE_LEVEL;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
